// File: rtl/rv32i_trap_ctrl_if.sv
// rv32i_trap_ctrl_if
//   Decode-side and fetch-redirect bus of the machine-mode trap sequencer.
//   master : pipeline side (drives decode info, consumes stall/flush/redirect)
//   slave  : trap sequencer side
//   Signals:
//     dec_valid, dec_pc, dec_inst          decode-stage instruction
//     is_inst_illegal, is_inst_addr_misaligned,
//     is_ecall, is_ebreak, is_mret         registered decoder flags
//     stall, flush                         pipeline hold / decode kill
//     redirect_valid, redirect_pc          PC load request
interface rv32i_trap_ctrl_if;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        is_inst_illegal;
  logic        is_inst_addr_misaligned;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output dec_valid, dec_pc, dec_inst,
    output is_inst_illegal, is_inst_addr_misaligned, is_ecall, is_ebreak, is_mret,
    input  stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  dec_valid, dec_pc, dec_inst,
    input  is_inst_illegal, is_inst_addr_misaligned, is_ecall, is_ebreak, is_mret,
    output stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/rv32i_trap_ctrl.sv
// rv32i_trap_ctrl
//   Machine-mode trap sequencer between decode and fetch. Captures an
//   exception, MRET or enabled interrupt for the instruction in decode,
//   stalls until older instructions drain, updates mepc/mcause/mtval and
//   mstatus.MIE/MPIE, then redirects fetch for one cycle.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     bus (slave)       decode info in; stall/flush/redirect out
//     irq_ext/sw/timer  level interrupt requests
//     mie_bits          {MEIE, MSIE, MTIE}
//     mtvec             trap vector base, [1:0]==01 selects vectored mode
//     drain_done        no older instruction left downstream
//     mepc, mcause, mtval, mstatus_mie, mstatus_mpie   owned trap CSRs
//     trap_busy         sequencer not idle
module rv32i_trap_ctrl (
  input  logic                    clk,
  input  logic                    rst,
  rv32i_trap_ctrl_if.slave        bus,
  input  logic                    irq_ext,
  input  logic                    irq_sw,
  input  logic                    irq_timer,
  input  logic [2:0]              mie_bits,
  input  logic [31:0]             mtvec,
  input  logic                    drain_done,
  output logic [31:0]             mepc,
  output logic [31:0]             mcause,
  output logic [31:0]             mtval,
  output logic                    mstatus_mie,
  output logic                    mstatus_mpie,
  output logic                    trap_busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ENTER    = 3'd2,
    ST_RETURN   = 3'd3,
    ST_REDIRECT = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  // Event captured in IDLE
  logic [31:0] cause_r;
  logic [31:0] tval_r;
  logic [31:0] pc_r;
  logic        is_ret_r;

  // Trap CSRs and redirect outputs
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic        mie_r;
  logic        mpie_r;
  logic [31:0] redirect_pc_r;
  logic        redirect_valid_r;
  logic        flush_r;

  // Event selection in the current cycle
  logic        take_s;
  logic        ret_s;
  logic [31:0] cause_s;
  logic [31:0] tval_s;
  logic [2:0]  irq_pend_s;
  logic        stall_s;

  // Trap target: direct base, or base + 4*cause for vectored interrupts
  function automatic logic [31:0] trap_vector(input logic [31:0] tvec,
                                              input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if ((tvec[1:0] == 2'b01) && cause[31]) begin
      trap_vector = base + {25'd0, cause[4:0], 2'b00};
    end else begin
      trap_vector = base;
    end
  endfunction

  assign irq_pend_s = {irq_ext & mie_bits[2], irq_sw & mie_bits[1], irq_timer & mie_bits[0]};

  // Priority selection: exceptions, then MRET, then globally enabled interrupts
  always_comb begin
    take_s  = 1'b0;
    ret_s   = 1'b0;
    cause_s = 32'd0;
    tval_s  = 32'd0;
    if (!bus.dec_valid) begin
      take_s = 1'b0;
    end else if (bus.is_inst_addr_misaligned) begin
      take_s  = 1'b1;
      cause_s = 32'd0;
      tval_s  = bus.dec_pc;
    end else if (bus.is_inst_illegal) begin
      take_s  = 1'b1;
      cause_s = 32'd2;
      tval_s  = bus.dec_inst;
    end else if (bus.is_ebreak) begin
      take_s  = 1'b1;
      cause_s = 32'd3;
    end else if (bus.is_ecall) begin
      take_s  = 1'b1;
      cause_s = 32'd11;
    end else if (bus.is_mret) begin
      take_s = 1'b1;
      ret_s  = 1'b1;
    end else if (mie_r && irq_pend_s[2]) begin
      take_s  = 1'b1;
      cause_s = 32'h8000_000B;
    end else if (mie_r && irq_pend_s[1]) begin
      take_s  = 1'b1;
      cause_s = 32'h8000_0003;
    end else if (mie_r && irq_pend_s[0]) begin
      take_s  = 1'b1;
      cause_s = 32'h8000_0007;
    end else begin
      take_s = 1'b0;
    end
  end

  // Next-state logic and combinational stall
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        stall_s = take_s;
        if (take_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!drain_done) begin
          next_state_s = ST_DRAIN;
        end else if (is_ret_r) begin
          next_state_s = ST_RETURN;
        end else begin
          next_state_s = ST_ENTER;
        end
      end
      ST_ENTER:    next_state_s = ST_REDIRECT;
      ST_RETURN:   next_state_s = ST_REDIRECT;
      ST_REDIRECT: next_state_s = ST_IDLE;
      default: begin
        next_state_s = ST_IDLE;
        stall_s      = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the selected event; held until the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_r  <= 32'd0;
      tval_r   <= 32'd0;
      pc_r     <= 32'd0;
      is_ret_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && take_s) begin
      cause_r  <= cause_s;
      tval_r   <= tval_s;
      pc_r     <= bus.dec_pc;
      is_ret_r <= ret_s;
    end
  end

  // CSR updates on leaving ENTER/RETURN, and the one-cycle redirect pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc_r           <= 32'd0;
      mcause_r         <= 32'd0;
      mtval_r          <= 32'd0;
      mie_r            <= 1'b0;
      mpie_r           <= 1'b1;
      redirect_pc_r    <= 32'd0;
      redirect_valid_r <= 1'b0;
      flush_r          <= 1'b0;
    end else begin
      redirect_valid_r <= (state_r == ST_ENTER) || (state_r == ST_RETURN);
      flush_r          <= (state_r == ST_ENTER) || (state_r == ST_RETURN);
      if (state_r == ST_ENTER) begin
        mepc_r        <= pc_r;
        mcause_r      <= cause_r;
        mtval_r       <= tval_r;
        mpie_r        <= mie_r;
        mie_r         <= 1'b0;
        redirect_pc_r <= trap_vector(mtvec, cause_r);
      end else if (state_r == ST_RETURN) begin
        mie_r         <= mpie_r;
        mpie_r        <= 1'b1;
        redirect_pc_r <= {mepc_r[31:2], 2'b00};
      end
    end
  end

  assign bus.stall          = stall_s;
  assign bus.flush          = flush_r;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign mepc               = mepc_r;
  assign mcause             = mcause_r;
  assign mtval              = mtval_r;
  assign mstatus_mie        = mie_r;
  assign mstatus_mpie       = mpie_r;
  assign trap_busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// tb_rv32i_trap_ctrl
//   Directed bench for the trap sequencer. Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge.
module tb_rv32i_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic [2:0]  mie_bits;
  logic [31:0] mtvec;
  logic        drain_done;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        trap_busy;

  int checks;
  int failures;
  int lat;

  rv32i_trap_ctrl_if bus ();

  rv32i_trap_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .irq_ext      (irq_ext),
    .irq_sw       (irq_sw),
    .irq_timer    (irq_timer),
    .mie_bits     (mie_bits),
    .mtvec        (mtvec),
    .drain_done   (drain_done),
    .mepc         (mepc),
    .mcause       (mcause),
    .mtval        (mtval),
    .mstatus_mie  (mstatus_mie),
    .mstatus_mpie (mstatus_mpie),
    .trap_busy    (trap_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_dec();
    bus.dec_valid               = 1'b0;
    bus.is_inst_illegal         = 1'b0;
    bus.is_inst_addr_misaligned = 1'b0;
    bus.is_ecall                = 1'b0;
    bus.is_ebreak               = 1'b0;
    bus.is_mret                 = 1'b0;
    irq_ext                     = 1'b0;
    irq_sw                      = 1'b0;
    irq_timer                   = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    bus.dec_valid = 1'b1;
    bus.dec_pc    = pc;
    bus.dec_inst  = inst;
  endtask

  // Event already presented in an IDLE cycle; measures cycles to redirect.
  task automatic run_event(input string tag, input int drain_low, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    chk({tag, "_cap_stall"}, {31'd0, bus.stall}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) clear_dec();
      drain_done = (k > drain_low);
      @(negedge clk);
      if (bus.redirect_valid) begin
        n = k;
        break;
      end
      chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd1);
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_flush"}, {31'd0, bus.flush}, 32'd1);
    chk({tag, "_busy"}, {31'd0, trap_busy}, 32'd1);
  endtask

  task automatic after_redirect(input string tag);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_rv_single"}, {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, trap_busy}, 32'd0);
  endtask

  initial begin
    int seen;
    checks     = 0;
    failures   = 0;
    lat        = 0;
    rst        = 1'b1;
    mie_bits   = 3'b000;
    mtvec      = 32'h0000_0200;
    drain_done = 1'b1;
    bus.dec_pc   = 32'd0;
    bus.dec_inst = 32'd0;
    clear_dec();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_mepc", mepc, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_mtval", mtval, 32'd0);
    chk("rst_mie", {31'd0, mstatus_mie}, 32'd0);
    chk("rst_mpie", {31'd0, mstatus_mpie}, 32'd1);
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    chk("rst_busy", {31'd0, trap_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Interrupt with MIE=0: no capture
    present(32'h0000_0040, 32'h0000_0013);
    irq_ext  = 1'b1;
    mie_bits = 3'b111;
    #1;
    chk("mask_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("mask_busy", {31'd0, trap_busy}, 32'd0);
    // dec_valid low: flags ignored
    clear_dec();
    bus.is_inst_illegal = 1'b1;
    #1;
    chk("novalid_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("novalid_busy", {31'd0, trap_busy}, 32'd0);
    clear_dec();

    // MRET straight out of reset sets MIE from MPIE=1
    present(32'h0000_0040, 32'h3020_0073);
    bus.is_mret = 1'b1;
    run_event("mret0", 0, 3);
    chk("mret0_rpc", bus.redirect_pc, 32'd0);
    chk("mret0_mie", {31'd0, mstatus_mie}, 32'd1);
    chk("mret0_mpie", {31'd0, mstatus_mpie}, 32'd1);
    after_redirect("mret0");

    // Illegal instruction
    @(posedge clk);
    #1;
    mtvec = 32'h0000_0200;
    present(32'h0000_0100, 32'hFFFF_FFFF);
    bus.is_inst_illegal = 1'b1;
    run_event("ill", 0, 3);
    chk("ill_rpc", bus.redirect_pc, 32'h0000_0200);
    chk("ill_mepc", mepc, 32'h0000_0100);
    chk("ill_mcause", mcause, 32'd2);
    chk("ill_mtval", mtval, 32'hFFFF_FFFF);
    chk("ill_mie", {31'd0, mstatus_mie}, 32'd0);
    chk("ill_mpie", {31'd0, mstatus_mpie}, 32'd1);

    // Back-to-back: misaligned + ecall, misaligned wins
    @(posedge clk);
    #1;
    present(32'h0000_0102, 32'h0000_0073);
    bus.is_inst_addr_misaligned = 1'b1;
    bus.is_ecall                = 1'b1;
    run_event("mis", 0, 3);
    chk("mis_mcause", mcause, 32'd0);
    chk("mis_mtval", mtval, 32'h0000_0102);
    chk("mis_mepc", mepc, 32'h0000_0102);
    chk("mis_rpc", bus.redirect_pc, 32'h0000_0200);
    chk("mis_mpie", {31'd0, mstatus_mpie}, 32'd0);
    after_redirect("mis");

    // ECALL with drain_done low for 4 cycles
    @(posedge clk);
    #1;
    drain_done = 1'b0;
    present(32'h0000_0104, 32'h0000_0073);
    bus.is_ecall = 1'b1;
    run_event("ecall", 4, 7);
    chk("ecall_mcause", mcause, 32'd11);
    chk("ecall_mtval", mtval, 32'd0);
    chk("ecall_mepc", mepc, 32'h0000_0104);

    // Back-to-back MRET: MIE restored from MPIE (0), MPIE set
    @(posedge clk);
    #1;
    present(32'h0000_0200, 32'h3020_0073);
    bus.is_mret = 1'b1;
    run_event("mret1", 0, 3);
    chk("mret1_rpc", bus.redirect_pc, 32'h0000_0104);
    chk("mret1_mie", {31'd0, mstatus_mie}, 32'd0);
    chk("mret1_mpie", {31'd0, mstatus_mpie}, 32'd1);
    after_redirect("mret1");

    // Second MRET re-enables MIE
    @(posedge clk);
    #1;
    present(32'h0000_0104, 32'h3020_0073);
    bus.is_mret = 1'b1;
    run_event("mret2", 0, 3);
    chk("mret2_mie", {31'd0, mstatus_mie}, 32'd1);
    after_redirect("mret2");

    // Timer pending but MTIE disabled: no capture
    @(posedge clk);
    #1;
    present(32'h0000_0300, 32'h0000_0013);
    mie_bits  = 3'b000;
    irq_timer = 1'b1;
    #1;
    chk("mtie_off_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("mtie_off_busy", {31'd0, trap_busy}, 32'd0);

    // Vectored timer interrupt
    mtvec    = 32'h0000_1001;
    mie_bits = 3'b001;
    run_event("tmr", 0, 3);
    chk("tmr_rpc", bus.redirect_pc, 32'h0000_101C);
    chk("tmr_mcause", mcause, 32'h8000_0007);
    chk("tmr_mtval", mtval, 32'd0);
    chk("tmr_mepc", mepc, 32'h0000_0300);
    chk("tmr_mie", {31'd0, mstatus_mie}, 32'd0);
    chk("tmr_mpie", {31'd0, mstatus_mpie}, 32'd1);
    after_redirect("tmr");

    // Reset asserted in DRAIN
    @(posedge clk);
    #1;
    present(32'h0000_0400, 32'h0000_0073);
    bus.is_ecall = 1'b1;
    drain_done   = 1'b0;
    @(posedge clk);
    #1;
    clear_dec();
    @(negedge clk);
    chk("rdr_busy_pre", {31'd0, trap_busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rdr_busy", {31'd0, trap_busy}, 32'd0);
    chk("rdr_stall", {31'd0, bus.stall}, 32'd0);
    chk("rdr_mepc", mepc, 32'd0);
    chk("rdr_mcause", mcause, 32'd0);
    chk("rdr_rpc", bus.redirect_pc, 32'd0);
    chk("rdr_mpie", {31'd0, mstatus_mpie}, 32'd1);
    drain_done = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.redirect_valid) seen = 1;
    end
    chk("rdr_no_redirect", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
